// File: rtl/conv_pkg.sv
// Shared types and size helpers for the parametrised 1-D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUT     = 2'd2
    } state_t;

    function automatic int calc_y(input int x_size, input int f_size);
        return x_size - f_size + 1;
    endfunction

    function automatic int calc_k(input int f_size, input int num_mac);
        return (f_size + num_mac - 1) / num_mac;
    endfunction

    // Address width that never collapses to zero bits for single-entry arrays.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int X_SIZE_DFLT  = 8;
    localparam int F_SIZE_DFLT  = 4;
    localparam int NUM_MAC_DFLT = 2;
    localparam int Y_SIZE       = calc_y(X_SIZE_DFLT, F_SIZE_DFLT);
    localparam int K            = calc_k(F_SIZE_DFLT, NUM_MAC_DFLT);
    localparam int X_ADDR_W     = width_of(X_SIZE_DFLT);
    localparam int F_ADDR_W     = width_of(F_SIZE_DFLT);

endpackage

// File: rtl/conv_mac_array.sv
// Combinational bank of NUM_MAC signed multipliers summed into one partial result.
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_F = 8,
    parameter int NUM_MAC      = 2,
    parameter int ACC_SIZE     = 18
) (
    input  logic [NUM_MAC*DATA_WIDTH_X-1:0] x_lanes,
    input  logic [NUM_MAC*DATA_WIDTH_F-1:0] f_lanes,
    input  logic [NUM_MAC-1:0]              lane_en,
    output logic signed [ACC_SIZE-1:0]      sum
);

    localparam int PW = DATA_WIDTH_X + DATA_WIDTH_F;

    logic signed [ACC_SIZE-1:0] prod_ext [NUM_MAC];

    for (genvar l = 0; l < NUM_MAC; l++) begin : g_mul
        logic signed [DATA_WIDTH_X-1:0] xv;
        logic signed [DATA_WIDTH_F-1:0] fv;
        logic signed [PW-1:0]           prod;

        assign xv   = $signed(x_lanes[l*DATA_WIDTH_X +: DATA_WIDTH_X]);
        assign fv   = $signed(f_lanes[l*DATA_WIDTH_F +: DATA_WIDTH_F]);
        assign prod = xv * fv;
        // Lanes past the last tap must add nothing.
        assign prod_ext[l] = lane_en[l] ? ACC_SIZE'(prod) : '0;
    end

    always_comb begin
        sum = '0;
        for (int l = 0; l < NUM_MAC; l++) begin
            sum = sum + prod_ext[l];
        end
    end

endmodule

// File: rtl/conv_nm_par.sv
// Streaming 1-D convolver: buffers X and F, then emits y[i] = sum_j x[i+j]*f[j]
// using NUM_MAC lanes per cycle, with optional filter hold across X vectors.
module conv_nm_par
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_F = 8,
    parameter int X_SIZE       = 8,
    parameter int F_SIZE       = 4,
    parameter int NUM_MAC      = 2,
    parameter int ACC_SIZE     = 18
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid_x,
    output logic                           s_ready_x,
    input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
    input  logic                           s_valid_f,
    output logic                           s_ready_f,
    input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
    input  logic                           s_hold_f,
    output logic                           m_valid_y,
    input  logic                           m_ready_y,
    output logic signed [ACC_SIZE-1:0]     m_data_out_y
);

    localparam int Y_LEN = calc_y(X_SIZE, F_SIZE);
    localparam int K_LEN = calc_k(F_SIZE, NUM_MAC);
    localparam int XAW   = width_of(X_SIZE);
    localparam int FAW   = width_of(F_SIZE);
    localparam int XCW   = $clog2(X_SIZE + 1);
    localparam int FCW   = $clog2(F_SIZE + 1);
    localparam int IW    = width_of(Y_LEN);
    localparam int KW    = width_of(K_LEN);

    localparam logic [XCW-1:0] X_CNT_FULL = XCW'(X_SIZE);
    localparam logic [XCW-1:0] X_CNT_LAST = XCW'(X_SIZE - 1);
    localparam logic [FCW-1:0] F_CNT_FULL = FCW'(F_SIZE);
    localparam logic [FCW-1:0] F_CNT_LAST = FCW'(F_SIZE - 1);
    localparam logic [IW-1:0]  I_LAST     = IW'(Y_LEN - 1);
    localparam logic [KW-1:0]  K_LAST     = KW'(K_LEN - 1);

    state_t state;

    logic signed [DATA_WIDTH_X-1:0] x_buf [X_SIZE];
    logic signed [DATA_WIDTH_F-1:0] f_buf [F_SIZE];

    logic [XCW-1:0] x_cnt;
    logic [FCW-1:0] f_cnt;
    logic [IW-1:0]  i_cnt;
    logic [KW-1:0]  k_cnt;
    logic           f_held;

    logic signed [ACC_SIZE-1:0] acc;
    logic signed [ACC_SIZE-1:0] acc_sum;
    logic signed [ACC_SIZE-1:0] mac_sum;

    logic x_full, f_full, x_fire, f_fire, x_full_nx, f_full_nx;

    assign x_full    = (x_cnt == X_CNT_FULL);
    assign f_full    = (f_cnt == F_CNT_FULL);
    assign s_ready_x = ~x_full;
    assign s_ready_f = ~f_full;
    assign x_fire    = s_valid_x & s_ready_x;
    assign f_fire    = s_valid_f & s_ready_f;
    // Looking one write ahead lets COMPUTE begin on the cycle right after the last load.
    assign x_full_nx = x_full | (x_fire & (x_cnt == X_CNT_LAST));
    assign f_full_nx = f_full | (f_fire & (f_cnt == F_CNT_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < X_SIZE; n++) x_buf[n] <= '0;
            for (int n = 0; n < F_SIZE; n++) f_buf[n] <= '0;
        end else begin
            if (x_fire) x_buf[x_cnt[XAW-1:0]] <= s_data_in_x;
            if (f_fire) f_buf[f_cnt[FAW-1:0]] <= s_data_in_f;
        end
    end

    logic [NUM_MAC*DATA_WIDTH_X-1:0] x_lanes;
    logic [NUM_MAC*DATA_WIDTH_F-1:0] f_lanes;
    logic [NUM_MAC-1:0]              lane_en;

    for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
        int             tap;
        logic [XAW-1:0] x_idx;
        logic [FAW-1:0] f_idx;

        assign tap        = int'(k_cnt) * NUM_MAC + l;
        assign lane_en[l] = (tap < F_SIZE);
        assign f_idx      = lane_en[l] ? FAW'(tap) : '0;
        assign x_idx      = lane_en[l] ? XAW'(int'(i_cnt) + tap) : '0;
        assign x_lanes[l*DATA_WIDTH_X +: DATA_WIDTH_X] = x_buf[x_idx];
        assign f_lanes[l*DATA_WIDTH_F +: DATA_WIDTH_F] = f_buf[f_idx];
    end

    conv_mac_array #(
        .DATA_WIDTH_X (DATA_WIDTH_X),
        .DATA_WIDTH_F (DATA_WIDTH_F),
        .NUM_MAC      (NUM_MAC),
        .ACC_SIZE     (ACC_SIZE)
    ) u_mac (
        .x_lanes (x_lanes),
        .f_lanes (f_lanes),
        .lane_en (lane_en),
        .sum     (mac_sum)
    );

    // First slice of each output starts from zero instead of the stale accumulator.
    assign acc_sum = (k_cnt == '0) ? mac_sum : acc + mac_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            x_cnt        <= '0;
            f_cnt        <= '0;
            i_cnt        <= '0;
            k_cnt        <= '0;
            f_held       <= 1'b0;
            acc          <= '0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
        end else begin
            if (x_fire) x_cnt <= x_cnt + 1'b1;
            if (f_fire) f_cnt <= f_cnt + 1'b1;
            case (state)
                LOAD: begin
                    if (x_full_nx && f_full_nx) begin
                        state  <= COMPUTE;
                        f_held <= s_hold_f;
                        i_cnt  <= '0;
                        k_cnt  <= '0;
                    end
                end
                COMPUTE: begin
                    if (k_cnt == K_LAST) begin
                        m_data_out_y <= acc_sum;
                        m_valid_y    <= 1'b1;
                        state        <= OUT;
                    end else begin
                        acc   <= acc_sum;
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        k_cnt     <= '0;
                        if (i_cnt == I_LAST) begin
                            state <= LOAD;
                            x_cnt <= '0;
                            if (!f_held) f_cnt <= '0;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_nm_par.sv
// Directed scoreboard bench for conv_nm_par (NUM_MAC=2 and NUM_MAC=3 instances share stimulus).
module tb_conv_nm_par;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_valid_x = 1'b0, s_valid_f = 1'b0, s_hold_f = 1'b0, m_ready_y = 1'b1;
    logic signed [7:0] s_data_in_x = '0, s_data_in_f = '0;
    logic s_ready_x, s_ready_f, m_valid_y;
    logic signed [17:0] m_data_out_y;
    logic s_ready_x3, s_ready_f3, m_valid3;
    logic signed [17:0] m_data3;

    int total = 0;
    int bad = 0;
    logic signed [17:0] sb [$];
    int  cur_f [4];
    bit  held_model = 1'b0;

    always #5 clk = ~clk;

    conv_nm_par #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(8), .F_SIZE(4),
                  .NUM_MAC(2), .ACC_SIZE(18)) dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x), .s_data_in_x(s_data_in_x),
        .s_valid_f(s_valid_f), .s_ready_f(s_ready_f), .s_data_in_f(s_data_in_f),
        .s_hold_f(s_hold_f),
        .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .m_data_out_y(m_data_out_y));

    conv_nm_par #(.DATA_WIDTH_X(8), .DATA_WIDTH_F(8), .X_SIZE(8), .F_SIZE(4),
                  .NUM_MAC(3), .ACC_SIZE(18)) dut3 (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x3), .s_data_in_x(s_data_in_x),
        .s_valid_f(s_valid_f), .s_ready_f(s_ready_f3), .s_data_in_f(s_data_in_f),
        .s_hold_f(s_hold_f),
        .m_valid_y(m_valid3), .m_ready_y(m_ready_y), .m_data_out_y(m_data3));

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every Y handshake, checks stall stability.
    bit prev_stall = 1'b0;
    logic signed [17:0] prev_data = '0;
    logic signed [17:0] exp_y;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid_y, 1);
                chk("stall_data", m_data_out_y, prev_data);
            end
            if (m_valid_y && m_ready_y) begin
                chk("y_expected_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_y = sb.pop_front();
                    chk("y_mac2", m_data_out_y, exp_y);
                    chk("y_valid_mac3", m_valid3, 1);
                    chk("y_mac3", m_data3, exp_y);
                end
            end
            prev_stall = m_valid_y && !m_ready_y;
            prev_data  = m_data_out_y;
        end
    end

    task automatic send(input int xv [8], input int fv [4], input bit send_f,
                        input bit hold, input bit toggle);
        int xi, fi, guard, y;
        bit fx, ff;
        if (send_f) cur_f = fv;
        held_model = hold;
        for (int i = 0; i < 5; i++) begin
            y = 0;
            for (int j = 0; j < 4; j++) y += xv[i+j] * cur_f[j];
            sb.push_back(18'(y));
        end
        s_hold_f = hold;
        xi = 0;
        fi = send_f ? 0 : 4;
        guard = 0;
        while ((xi < 8 || fi < 4) && guard < 200) begin
            s_valid_x = (xi < 8) && (!toggle || $urandom_range(0, 1) == 1);
            if (xi < 8) s_data_in_x = 8'(xv[xi]);
            s_valid_f = (fi < 4) && (!toggle || $urandom_range(0, 1) == 1);
            if (fi < 4) s_data_in_f = 8'(fv[fi]);
            @(negedge clk);
            fx = s_valid_x && s_ready_x;
            ff = s_valid_f && s_ready_f;
            @(posedge clk); #1;
            if (fx) xi++;
            if (ff) fi++;
            guard++;
        end
        chk("load_within_budget", guard < 200, 1);
        s_hold_f    = ~hold;
        s_valid_x   = toggle;
        s_valid_f   = toggle;
        s_data_in_x = 8'($urandom);
        s_data_in_f = 8'($urandom);
        chk("rdy_x_after_load", s_ready_x, 0);
        chk("rdy_f_after_load", s_ready_f, 0);
        chk("rdy_x3_after_load", s_ready_x3, 0);
        chk("vld_lat1", m_valid_y, 0);
        @(posedge clk); #1;
        s_valid_x = toggle && ($urandom_range(0, 1) == 1);
        chk("rdy_x_compute", s_ready_x, 0);
        chk("rdy_f_compute", s_ready_f, 0);
        chk("vld_lat2", m_valid_y, 0);
        @(posedge clk); #1;
        chk("vld_lat3", m_valid_y, 1);
        chk("vld3_lat3", m_valid3, 1);
    endtask

    task automatic drain(input bit bp, input bit toggle);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            m_ready_y = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (toggle) begin
                s_valid_x   = ($urandom_range(0, 1) == 1);
                s_valid_f   = ($urandom_range(0, 1) == 1);
                s_data_in_x = 8'($urandom);
                s_data_in_f = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (sb.size() > 0) begin
                chk("rdy_x_busy", s_ready_x, 0);
                chk("rdy_f_busy", s_ready_f, 0);
            end
        end
        chk("drain_within_budget", n < 400, 1);
        chk("rdy_x_release", s_ready_x, 1);
        chk("rdy_f_release", s_ready_f, !held_model);
        chk("rdy_f3_release", s_ready_f3, !held_model);
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        m_ready_y = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int xa [8], xr [8], xm [8], xb [8];
    int fa [4], fm [4], fx [4], fb [4];

    initial begin
        xa = '{1, 2, 3, 4, 5, 6, 7, 8};
        xr = '{8, 7, 6, 5, 4, 3, 2, 1};
        xm = '{-128, -128, -128, -128, -128, -128, -128, -128};
        xb = '{3, -5, 127, 0, -1, 64, -100, 9};
        fa = '{1, 1, 1, 1};
        fx = '{-128, -128, -128, -128};
        fm = '{1, -1, 1, -1};
        fb = '{2, 0, -1, 3};

        #1 reset = 1'b0;
        #1;
        chk("rst_ready_x", s_ready_x, 1);
        chk("rst_ready_f", s_ready_f, 1);
        chk("rst_valid_y", m_valid_y, 0);
        chk("rst_data_y", m_data_out_y, 0);
        chk("rst_valid_y3", m_valid3, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Basic ramp against unit filter
        send(xa, fa, 1'b1, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        // Extremes and alternating signs
        send(xm, fx, 1'b1, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        send(xa, fm, 1'b1, 1'b0, 1'b0);
        drain(1'b0, 1'b0);
        // Output backpressure with input valid noise
        send(xa, fa, 1'b1, 1'b0, 1'b1);
        drain(1'b1, 1'b1);
        send(xb, fb, 1'b1, 1'b0, 1'b1);
        drain(1'b1, 1'b1);
        // Filter hold over two rounds, then release on the third
        send(xa, fa, 1'b1, 1'b1, 1'b0);
        drain(1'b0, 1'b0);
        send(xr, fa, 1'b0, 1'b1, 1'b0);
        drain(1'b0, 1'b0);
        send(xa, fa, 1'b0, 1'b0, 1'b0);
        drain(1'b1, 1'b0);

        // Reset pulled low while the first Y is stalled
        m_ready_y = 1'b0;
        send(xa, fa, 1'b1, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        chk("midout_rst_valid", m_valid_y, 0);
        chk("midout_rst_ready_x", s_ready_x, 1);
        chk("midout_rst_ready_f", s_ready_f, 1);
        chk("midout_rst_data", m_data_out_y, 0);
        chk("midout_rst_valid3", m_valid3, 0);
        sb.delete();
        held_model = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_ready_y = 1'b1;
        send(xb, fb, 1'b1, 1'b0, 1'b0);
        drain(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_nm_par.md
# conv_nm_par

Parametrised 1-D convolution engine, the successor of the fixed 8×4 convolver. Streams in an X vector of X_SIZE signed samples and an F vector of F_SIZE signed taps over valid/ready handshakes, then streams out X_SIZE−F_SIZE+1 results y[i] = Σ_j x[i+j]·f[j]. Each result uses NUM_MAC multipliers in parallel. An optional filter-hold mode keeps F resident across X vectors. The block sits between the X/F stream sources and the Y stream sink at the top of the datapath.

## Interface
- DATA_WIDTH_X, 8, signed X sample width
- DATA_WIDTH_F, 8, signed F tap width
- X_SIZE, 8, samples per X vector (≥ F_SIZE)
- F_SIZE, 4, taps per F vector (≥ 1)
- NUM_MAC, 2, parallel multipliers (1..F_SIZE)
- ACC_SIZE, 18, accumulator/output width (≥ DATA_WIDTH_X+DATA_WIDTH_F+$clog2(F_SIZE))
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low; all state cleared while low
- s_valid_x / s_ready_x / s_data_in_x  in/out/in  1/1/DATA_WIDTH_X  X stream
- s_valid_f / s_ready_f / s_data_in_f  in/out/in  1/1/DATA_WIDTH_F  F stream
- s_hold_f  in  1  filter-hold request, sampled at compute start
- m_valid_y / m_ready_y / m_data_out_y  out/in/out  1/1/ACC_SIZE signed  Y stream

## Operation
- Reset values: s_ready_x=1, s_ready_f=1, m_valid_y=0, m_data_out_y=0, f_held=0, state LOAD.
- Transfer occurs when valid&&ready on a posedge. X fills addresses 0..X_SIZE−1 in order, and F fills 0..F_SIZE−1 in order. Both streams load independently and concurrently.
- When a buffer holds SIZE entries, its s_ready deasserts the following cycle. Valid asserted while ready is low is ignored; no data is lost or overwritten.
- States:
  - LOAD: advance to COMPUTE once both buffers are full.
  - COMPUTE: K = ceil(F_SIZE/NUM_MAC) cycles. Cycle k multiplies lanes j = k·NUM_MAC+l against x[i+j] and accumulates. Lanes with j ≥ F_SIZE contribute 0. The accumulator clears at the start of each i.
  - OUT: m_valid_y=1 and m_data_out_y=y[i], both held stable until m_ready_y.
    - On handshake with i < X_SIZE−F_SIZE: i++, go to COMPUTE.
    - On handshake with the last i: go to LOAD.
- Arithmetic: products are full-precision signed (DATA_WIDTH_X+DATA_WIDTH_F), sign-extended to ACC_SIZE, and summed two's-complement. No saturation or rounding.
- Filter hold:
  - s_hold_f is sampled on the LOAD→COMPUTE transition into f_held.
  - At the end of a vector, X always empties.
  - F empties only if f_held=0. If f_held=1, F stays full, s_ready_f stays 0, and the next round waits for X only.
  - f_held is resampled at every compute start, so s_hold_f=0 at the next start releases F after that round.
- s_hold_f has no effect outside the LOAD→COMPUTE transition.

## Timing
- The last input handshake (cycle t) causes s_ready of that stream to be 0 at t+1. COMPUTE runs t+1..t+K, and m_valid_y=1 at t+K+1.
- With m_ready_y held high, one y is produced every K+1 cycles. A vector takes (X_SIZE−F_SIZE+1)·(K+1) cycles after load.
- Buffer release: s_ready_x (and s_ready_f unless held) return to 1 on the cycle after the final Y handshake. New loads are accepted from that cycle.
- Backpressure: m_ready_y=0 stalls in OUT indefinitely with the output unchanged. It does not affect the input side, because both buffers are already full.
- Reset low at any point, including mid-COMPUTE or mid-OUT: outputs return to reset values asynchronously. The partial vector is discarded, f_held is cleared, and the first posedge after release is in LOAD.

## Structure
- Package conv_pkg:
  - derived constants: Y_SIZE = X_SIZE−F_SIZE+1, K, and address widths via $clog2
  - state enum typedef {LOAD, COMPUTE, OUT}
- Sub-module conv_mac_array: NUM_MAC signed multipliers plus an adder tree. It is combinational, with lane-enable masking for j ≥ F_SIZE.
- The top level holds the buffers, counters (i, k, write addresses), FSM, accumulator, and output register.

## Test plan
- Defaults, X=1..8, F=1,1,1,1, m_ready_y=1 → Y=10,14,18,22,26; the first m_valid_y appears K+1=3 cycles after the last input.
- Extremes: X all −128, F all −128 → every y = 65536 with no wrap. Mixed signs, X=1..8, F=1,−1,1,−1 → every y = −2.
- Backpressure: random m_ready_y gaps, and s_valid toggling during compute → same Y sequence, output stable while stalled, s_ready_x and s_ready_f both 0 throughout compute.
- Filter hold: round 1 with s_hold_f=1, F=1,1,1,1, X=1..8. Round 2 sends only X=8..1 → Y=26,22,18,14,10, and s_ready_f stays 0 across the boundary.
- Filter release: same as filter hold, but with s_hold_f=0 at the round-2 start → s_ready_f=1 after round 2.
- NUM_MAC=3, F_SIZE=4 (K=2, lane masking), defaults otherwise → same Y as the first scenario.
- Reset pulled low mid-OUT → immediately m_valid_y=0, s_ready_x=1, s_ready_f=1. A fresh load afterwards gives correct Y.
